// File: rtl/fruit_trajectory_ctrl.sv
// Per-fruit motion controller: launches a sprite from the floor, flies it on a ballistic arc, handles slice/miss.
// Defining FRUIT_STATS_EN adds saturating slice_count/miss_count outputs.
module fruit_trajectory_ctrl #(
  parameter int          SCREEN_W       = 640,
  parameter int          SCREEN_H       = 480,
  parameter int          SPRITE_SIZE    = 50,
  parameter int          LAUNCH_VY      = 18,
  parameter int          GRAVITY        = 1,
  parameter int          VX_MAG         = 3,
  parameter int          RESPAWN_FRAMES = 60,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic       sliced,
  output logic [9:0] x_pos,
  output logic [8:0] y_pos,
  output logic       visible,
  output logic       missed
`ifdef FRUIT_STATS_EN
  ,
  output logic [7:0] slice_count,
  output logic [7:0] miss_count
`endif
);

  localparam logic        [9:0]  X_MAX_U     = 10'(SCREEN_W - SPRITE_SIZE);
  localparam logic        [9:0]  X_HALF_U    = 10'(SCREEN_W / 2);
  localparam logic        [8:0]  Y_FLOOR_U   = 9'(SCREEN_H - SPRITE_SIZE);
  localparam logic signed [10:0] X_MAX_S     = 11'(SCREEN_W - SPRITE_SIZE);
  localparam logic signed [10:0] Y_FLOOR_S   = 11'(SCREEN_H - SPRITE_SIZE);
  localparam logic signed [10:0] LAUNCH_VY_S = 11'(LAUNCH_VY);
  localparam logic signed [10:0] GRAV_S      = 11'(GRAVITY);
  localparam logic signed [10:0] VX_S        = 11'(VX_MAG);
  localparam logic signed [10:0] ZERO_S      = 11'sd0;
  localparam logic        [7:0]  CNT_LAST    = 8'(RESPAWN_FRAMES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FLYING, ST_SLICED} state_t;

  state_t                state_q;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [9:0]            x_q, x_d, launch_x_d;
  logic [8:0]            y_q, y_d;
  logic signed [10:0]    vx_q, vx_d, vy_q, vy_n, launch_vx_d;
  logic signed [10:0]    x_n, y_n;
  logic [7:0]            cnt_q;
  logic                  vis_q, missed_q, land;

  // Sprite cannot rise above the top edge; vy keeps integrating regardless.
  function automatic logic [8:0] clamp_top(input logic signed [10:0] v);
    return (v < ZERO_S) ? 9'd0 : 9'(v);
  endfunction

  always_comb begin
    lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    // Values past the right edge fold back by 512 so every launch lands on-screen.
    launch_x_d  = (lfsr_q[9:0] > X_MAX_U) ? (lfsr_q[9:0] - 10'd512) : lfsr_q[9:0];
    launch_vx_d = (launch_x_d < X_HALF_U) ? VX_S : -VX_S;
    x_n         = $signed({1'b0, x_q}) + vx_q;
    y_n         = $signed({2'b00, y_q}) + vy_q;
    vy_n        = vy_q + GRAV_S;
    land        = (vy_q > ZERO_S) && (y_n >= Y_FLOOR_S);
    y_d         = clamp_top(y_n);
    x_d         = 10'(x_n);
    vx_d        = vx_q;
    if (x_n < ZERO_S) begin
      x_d  = 10'd0;
      vx_d = -vx_q;
    end else if (x_n > X_MAX_S) begin
      x_d  = X_MAX_U;
      vx_d = -vx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= ST_IDLE;
      lfsr_q   <= LFSR_SEED;
      x_q      <= 10'd0;
      y_q      <= Y_FLOOR_U;
      vx_q     <= ZERO_S;
      vy_q     <= ZERO_S;
      cnt_q    <= 8'd0;
      vis_q    <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_d;
      missed_q <= 1'b0;
      if (enable) begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_WAIT;
            cnt_q   <= 8'd0;
          end
          ST_WAIT: begin
            if (frame_tick) begin
              if (cnt_q == CNT_LAST) begin
                state_q <= ST_FLYING;
                x_q     <= launch_x_d;
                y_q     <= Y_FLOOR_U;
                vx_q    <= launch_vx_d;
                vy_q    <= -LAUNCH_VY_S;
                vis_q   <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 8'd1;
              end
            end
          end
          ST_FLYING: begin
            // A slice takes priority over a coincident frame tick: no motion that cycle.
            if (sliced) begin
              state_q <= ST_SLICED;
              vx_q    <= ZERO_S;
              if (vy_q < ZERO_S) vy_q <= ZERO_S;
            end else if (frame_tick) begin
              x_q  <= x_d;
              vx_q <= vx_d;
              vy_q <= vy_n;
              if (land) begin
                y_q      <= Y_FLOOR_U;
                vis_q    <= 1'b0;
                missed_q <= 1'b1;
                state_q  <= ST_WAIT;
                cnt_q    <= 8'd0;
              end else begin
                y_q <= y_d;
              end
            end
          end
          ST_SLICED: begin
            if (frame_tick) begin
              vy_q <= vy_n;
              if (land) begin
                y_q     <= Y_FLOOR_U;
                vis_q   <= 1'b0;
                state_q <= ST_WAIT;
                cnt_q   <= 8'd0;
              end else begin
                y_q <= y_d;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign x_pos   = x_q;
  assign y_pos   = y_q;
  assign visible = vis_q;
  assign missed  = missed_q;

`ifdef FRUIT_STATS_EN
  logic [7:0] slice_cnt_q, miss_cnt_q;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      slice_cnt_q <= 8'd0;
      miss_cnt_q  <= 8'd0;
    end else if (enable && (state_q == ST_FLYING)) begin
      if (sliced) begin
        slice_cnt_q <= sat_inc8(slice_cnt_q);
      end else if (frame_tick && land) begin
        miss_cnt_q <= sat_inc8(miss_cnt_q);
      end
    end
  end

  assign slice_count = slice_cnt_q;
  assign miss_count  = miss_cnt_q;
`endif

endmodule

// File: tb/tb_fruit_trajectory_ctrl.sv
// Testbench for fruit_trajectory_ctrl: directed flights plus random stimulus against a behavioural model.
`timescale 1ns/1ps
module tb_fruit_trajectory_ctrl;

  localparam int          XMAX = 590;
  localparam int          YFL  = 430;
  localparam int          LVY  = 18;
  localparam int          GRV  = 1;
  localparam int          VXM  = 3;
  localparam int          RESP = 60;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       frame_tick = 1'b0;
  logic       sliced = 1'b0;
  logic [9:0] x_pos;
  logic [8:0] y_pos;
  logic       visible, missed;
`ifdef FRUIT_STATS_EN
  logic [7:0] slice_count, miss_count;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fruit_trajectory_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .frame_tick (frame_tick),
    .sliced     (sliced),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .visible    (visible),
    .missed     (missed)
`ifdef FRUIT_STATS_EN
    ,
    .slice_count(slice_count),
    .miss_count (miss_count)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int launch_x(input int r);
    return (r > XMAX) ? r - 512 : r;
  endfunction

  function automatic void move_x(input int x, input int vx, output int xn, output int vxn);
    xn  = x + vx;
    vxn = vx;
    if (xn < 0) begin
      xn  = 0;
      vxn = -vx;
    end else if (xn > XMAX) begin
      xn  = XMAX;
      vxn = -vx;
    end
  endfunction

  function automatic void fall(input int y, input int vy, output int yn, output bit landed);
    yn     = y + vy;
    landed = (vy > 0) && (yn >= YFL);
    if (yn < 0) yn = 0;
  endfunction

  function automatic int arc_y(input int k);
    int y, vy, yn;
    bit l;
    y  = YFL;
    vy = -LVY;
    for (int i = 0; i < k; i++) begin
      fall(y, vy, yn, l);
      y  = yn;
      vy = vy + GRV;
    end
    return y;
  endfunction

  function automatic int land_tick();
    int y, vy, yn;
    bit l;
    y  = YFL;
    vy = -LVY;
    for (int t = 1; t < 200; t++) begin
      fall(y, vy, yn, l);
      if (l) return t;
      y  = yn;
      vy = vy + GRV;
    end
    return -1;
  endfunction

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // phase: 0 idle, 1 waiting for launch, 2 in flight, 3 falling after a cut
  int          m_phase, mx, my, mvx, mvy, mticks, m_slices, m_misses;
  int          n_launch = 0;
  bit          mvis, mmiss;
  bit          m_ready = 1'b0;
  logic [15:0] m_lfsr;

  always @(posedge clk) begin : model
    int r, xn, vxn, yn;
    bit landed;
    if (!resetn) begin
      m_lfsr   = SEED;
      m_phase  = 0;
      mx       = 0;
      my       = YFL;
      mvx      = 0;
      mvy      = 0;
      mvis     = 1'b0;
      mmiss    = 1'b0;
      mticks   = 0;
      m_slices = 0;
      m_misses = 0;
      m_ready  = 1'b1;
    end else begin
      r      = int'(m_lfsr[9:0]);
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      mmiss  = 1'b0;
      if (enable) begin
        if (m_phase == 0) begin
          m_phase = 1;
          mticks  = 0;
        end else if (m_phase == 1) begin
          if (frame_tick) begin
            mticks++;
            if (mticks == RESP) begin
              mx      = launch_x(r);
              my      = YFL;
              mvy     = -LVY;
              mvx     = (mx < 320) ? VXM : -VXM;
              mvis    = 1'b1;
              m_phase = 2;
              n_launch++;
            end
          end
        end else if (m_phase == 2) begin
          if (sliced) begin
            m_phase  = 3;
            mvx      = 0;
            if (mvy < 0) mvy = 0;
            m_slices = sat255(m_slices + 1);
          end else if (frame_tick) begin
            move_x(mx, mvx, xn, vxn);
            mx  = xn;
            mvx = vxn;
            fall(my, mvy, yn, landed);
            mvy = mvy + GRV;
            if (landed) begin
              my       = YFL;
              mvis     = 1'b0;
              mmiss    = 1'b1;
              m_phase  = 1;
              mticks   = 0;
              m_misses = sat255(m_misses + 1);
            end else begin
              my = yn;
            end
          end
        end else begin
          if (frame_tick) begin
            fall(my, mvy, yn, landed);
            mvy = mvy + GRV;
            if (landed) begin
              my      = YFL;
              mvis    = 1'b0;
              m_phase = 1;
              mticks  = 0;
            end else begin
              my = yn;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ready) begin
      chk("x_pos", int'(x_pos), mx);
      chk("y_pos", int'(y_pos), my);
      chk("visible", int'(visible), int'(mvis));
      chk("missed", int'(missed), int'(mmiss));
`ifdef FRUIT_STATS_EN
      chk("slice_count", int'(slice_count), m_slices);
      chk("miss_count", int'(miss_count), m_misses);
`endif
    end
  end

  bit miss_seen = 1'b0;
  always @(negedge clk) if (missed) miss_seen = 1'b1;

  // ---------------- stimulus ----------------
  task automatic do_tick(input bit with_slice);
    @(negedge clk);
    frame_tick = 1'b1;
    sliced     = with_slice;
    @(negedge clk);
    frame_tick = 1'b0;
    sliced     = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, int'(x_pos), 0);
    chk({tag, "_y"}, int'(y_pos), 430);
    chk({tag, "_vis"}, int'(visible), 0);
    chk({tag, "_missed"}, int'(missed), 0);
  endtask

  int xo, vo;

  initial begin
    // model pins against hand-computed values
    move_x(589, 3, xo, vo);
    chk("pin_bounce_hi_x", xo, 590);
    chk("pin_bounce_hi_vx", vo, -3);
    move_x(xo, vo, xo, vo);
    chk("pin_bounce_next_x", xo, 587);
    move_x(1, -3, xo, vo);
    chk("pin_bounce_lo_x", xo, 0);
    chk("pin_bounce_lo_vx", vo, 3);
    chk("pin_launch_wrap", launch_x(600), 88);
    chk("pin_launch_keep", launch_x(590), 590);
    chk("pin_tick1_y", arc_y(1), 412);
    chk("pin_apex_y", arc_y(18), 259);
    chk("pin_land_tick", land_tick(), 37);

    // reset
    resetn = 1'b0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    resetn = 1'b1;
    enable = 1'b1;
    repeat (2) @(negedge clk);

    // flight 1: full unsliced arc
    for (int i = 0; i < RESP; i++) do_tick(1'b0);
    chk("launch_vis", int'(visible), 1);
    chk("launch_y", int'(y_pos), 430);
    chk("launch_x_range", (x_pos <= 10'd590) ? 1 : 0, 1);
    do_tick(1'b0);
    chk("arc_tick1_y", int'(y_pos), 412);
    for (int i = 2; i <= 18; i++) do_tick(1'b0);
    chk("arc_apex_y", int'(y_pos), 259);
    for (int i = 19; i <= 36; i++) do_tick(1'b0);
    chk("arc_tick36_vis", int'(visible), 1);
    do_tick(1'b0);
    chk("arc_land_y", int'(y_pos), 430);
    chk("arc_land_vis", int'(visible), 0);
    chk("arc_land_missed", int'(missed), 1);
    @(negedge clk);
    chk("arc_missed_pulse_end", int'(missed), 0);

    // flight 2: slice at tick 5, coincident with a frame tick
    for (int i = 0; i < RESP; i++) do_tick(1'b0);
    for (int i = 0; i < 5; i++) do_tick(1'b0);
    chk("pre_slice_y", int'(y_pos), 350);
    do_tick(1'b1);
    chk("slice_no_motion_y", int'(y_pos), 350);
    chk("slice_vis", int'(visible), 1);
    miss_seen = 1'b0;
    for (int i = 0; i < 100 && visible; i++) do_tick(1'b0);
    chk("slice_landed", int'(visible), 0);
    repeat (2) @(negedge clk);
    chk("slice_no_missed", int'(miss_seen), 0);

    // flight 3: freeze mid-flight, then reset mid-flight
    for (int i = 0; i < RESP; i++) do_tick(1'b0);
    for (int i = 0; i < 10; i++) do_tick(1'b0);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) do_tick(bit'(i % 2));
    enable = 1'b1;
    for (int i = 0; i < 5; i++) do_tick(1'b0);
    chk("post_freeze_vis", int'(visible), 1);
    @(negedge clk);
    resetn     = 1'b0;
    frame_tick = 1'b1;
    sliced     = 1'b1;
    @(negedge clk);
    chk_reset_vals("midflight_reset");
    resetn     = 1'b1;
    frame_tick = 1'b0;
    sliced     = 1'b0;

    // random phase
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      frame_tick = ($urandom_range(0, 2) == 0);
      sliced     = ($urandom_range(0, 149) == 0);
      if (enable) enable = ($urandom_range(0, 199) != 0);
      else        enable = ($urandom_range(0, 9) == 0);
      resetn     = ($urandom_range(0, 2999) != 0);
    end
    @(negedge clk);
    frame_tick = 1'b0;
    sliced     = 1'b0;
    resetn     = 1'b1;
    repeat (2) @(negedge clk);
    chk("launches_exercised", (n_launch >= 10) ? 1 : 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
